// File: rtl/i2s_adc_rx.sv
// I2S ADC receiver: oversamples the codec bit/word clocks on Clk, deframes
// left/right words and presents them as a pair with a valid/ready handshake.
module i2s_adc_rx #(
    parameter int DATA_W = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              AUD_BCLK,
    input  logic              AUD_ADCLRCK,
    input  logic              AUD_ADCDAT,
    input  logic              ready,
    input  logic              clr_ovr,
    output logic [DATA_W-1:0] LDATA_IN,
    output logic [DATA_W-1:0] RDATA_IN,
    output logic              valid,
    output logic              overrun,
    output logic              locked
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SKIP,
        SHIFT,
        DONE
    } state_t;

    logic              bclk_s1_q, bclk_s2_q, bclk_h_q;
    logic              lrck_s1_q, lrck_s2_q, lrck_h_q;
    logic              dat_s1_q, dat_s2_q;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] lstage_q;
    logic [DATA_W-1:0] rstage_q;
    logic              chan_q;
    logic              left_ok_q;
    logic              pair_q;
    logic              locked_q;

    logic [DATA_W-1:0] ldata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              valid_q;
    logic              overrun_q;

    logic              bit_evt;
    logic              lr_edge;
    logic [DATA_W-1:0] word_d;

    // The LRCK history only advances on bit events, so a word-clock change
    // that lands between BCLK rises is still seen at the next rise.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bclk_s1_q <= 1'b0;
            bclk_s2_q <= 1'b0;
            bclk_h_q  <= 1'b0;
            lrck_s1_q <= 1'b0;
            lrck_s2_q <= 1'b0;
            lrck_h_q  <= 1'b0;
            dat_s1_q  <= 1'b0;
            dat_s2_q  <= 1'b0;
        end else begin
            bclk_s1_q <= AUD_BCLK;
            bclk_s2_q <= bclk_s1_q;
            bclk_h_q  <= bclk_s2_q;
            lrck_s1_q <= AUD_ADCLRCK;
            lrck_s2_q <= lrck_s1_q;
            if (bit_evt) begin
                lrck_h_q <= lrck_s2_q;
            end
            dat_s1_q  <= AUD_ADCDAT;
            dat_s2_q  <= dat_s1_q;
        end
    end

    assign bit_evt = bclk_s2_q & ~bclk_h_q;
    assign lr_edge = bit_evt & (lrck_s2_q ^ lrck_h_q);
    assign word_d  = {shift_q[DATA_W-2:0], dat_s2_q};

    // A word-clock edge restarts framing from any state; a right word only
    // forms a pair if a complete left word was staged earlier in the frame.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            lstage_q  <= '0;
            rstage_q  <= '0;
            chan_q    <= 1'b0;
            left_ok_q <= 1'b0;
            pair_q    <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            pair_q <= 1'b0;
            if (lr_edge) begin
                state_q  <= SKIP;
                chan_q   <= lrck_s2_q;
                locked_q <= 1'b1;
                if (!lrck_s2_q) begin
                    left_ok_q <= 1'b0;
                end
            end else if (bit_evt) begin
                case (state_q)
                    SKIP: begin
                        state_q <= SHIFT;
                        cnt_q   <= '0;
                    end
                    SHIFT: begin
                        shift_q <= word_d;
                        cnt_q   <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_BIT) begin
                            state_q <= DONE;
                            if (!chan_q) begin
                                lstage_q  <= word_d;
                                left_ok_q <= 1'b1;
                            end else begin
                                rstage_q  <= word_d;
                                pair_q    <= left_ok_q;
                                left_ok_q <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_q <= state_q;
                    end
                endcase
            end
        end
    end

    // Output pair register: a completed pair loads when the slot is free or
    // being emptied this cycle, otherwise it is dropped and flagged.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ldata_q   <= '0;
            rdata_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (pair_q && valid_q && !ready) begin
                overrun_q <= 1'b1;
            end else if (clr_ovr) begin
                overrun_q <= 1'b0;
            end

            if (pair_q && (!valid_q || ready)) begin
                ldata_q <= lstage_q;
                rdata_q <= rstage_q;
                valid_q <= 1'b1;
            end else if (valid_q && ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign LDATA_IN = ldata_q;
    assign RDATA_IN = rdata_q;
    assign valid    = valid_q;
    assign overrun  = overrun_q;
    assign locked   = locked_q;

endmodule
